// File: rtl/commit_trace_if.sv
// Commit-side and trace-side signals of commit_trace_buffer.
// master: retirement source plus trace consumer; slave: the trace buffer.
interface commit_trace_if;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [31:0] ret_inst;
  logic        ret_reg_write;
  logic [4:0]  ret_write_reg;
  logic [31:0] ret_write_data;
  logic        ret_mem_read;
  logic        ret_mem_write;
  logic [31:0] ret_mem_addr;
  logic [31:0] ret_mem_data;
  logic        ret_halt;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inum;
  logic [2:0]  out_kind;
  logic [31:0] out_pc;
  logic [4:0]  out_reg;
  logic [31:0] out_value;
  logic [31:0] out_addr;
  logic [31:0] out_data;

  modport master (
    output ret_valid, ret_pc, ret_inst, ret_reg_write, ret_write_reg, ret_write_data,
           ret_mem_read, ret_mem_write, ret_mem_addr, ret_mem_data, ret_halt, out_ready,
    input  out_valid, out_inum, out_kind, out_pc, out_reg, out_value, out_addr, out_data
  );

  modport slave (
    input  ret_valid, ret_pc, ret_inst, ret_reg_write, ret_write_reg, ret_write_data,
           ret_mem_read, ret_mem_write, ret_mem_addr, ret_mem_data, ret_halt, out_ready,
    output out_valid, out_inum, out_kind, out_pc, out_reg, out_value, out_addr, out_data
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Numbers retiring instructions into trace records and buffers them in a registered FIFO.
// Optional: define COMMIT_TRACE_FILTER_EN to drop kind-0 (branch/NOP) records while keeping numbering.
module commit_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  commit_trace_if.slave         tr,
  output logic                  halted,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_count,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0] inum;
    logic [2:0]  kind;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  state_t           stateReg, stateNext;
  rec_t             mem [DEPTH];
  rec_t             recNext;
  rec_t             headRec;
  logic [2:0]       kind;
  logic [AW-1:0]    wrPtrReg, rdPtrReg;
  logic [LW-1:0]    levelReg, levelNext;
  logic [31:0]      inumReg, inumNext;
  logic             overflowReg, overflowNext;
  logic [CNT_W-1:0] dropReg, dropNext;
  logic             doneReg, doneNext;
  logic             accept, pushReq, push, pop, drop;

  // Record kind, first match wins.
  always_comb begin
    kind = 3'd0;
    if (tr.ret_halt)                              kind = 3'd5;
    else if (tr.ret_reg_write && tr.ret_mem_write) kind = 3'd4;
    else if (tr.ret_reg_write && tr.ret_mem_read)  kind = 3'd2;
    else if (tr.ret_reg_write)                     kind = 3'd1;
    else if (tr.ret_mem_write)                     kind = 3'd3;
  end

  // Only the fields meaningful for the kind are carried; the rest stay zero.
  always_comb begin
    recNext      = '0;
    recNext.inum = inumReg;
    recNext.kind = kind;
    recNext.pc   = tr.ret_pc;
    case (kind)
      3'd1: begin
        recNext.rd    = tr.ret_write_reg;
        recNext.value = tr.ret_write_data;
      end
      3'd2: begin
        recNext.rd    = tr.ret_write_reg;
        recNext.value = tr.ret_write_data;
        recNext.addr  = tr.ret_mem_addr;
      end
      3'd3: begin
        recNext.addr  = tr.ret_mem_addr;
        recNext.data  = tr.ret_mem_data;
      end
      3'd4: begin
        recNext.rd    = tr.ret_write_reg;
        recNext.value = tr.ret_write_data;
        recNext.addr  = tr.ret_mem_addr;
        recNext.data  = tr.ret_mem_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    stateNext    = stateReg;
    accept       = tr.ret_valid && (stateReg == RUN);
`ifdef COMMIT_TRACE_FILTER_EN
    pushReq      = accept && (kind != 3'd0);
`else
    pushReq      = accept;
`endif
    pop          = (levelReg != '0) && tr.out_ready;
    push         = pushReq && ((levelReg != FULL_LEVEL) || pop);
    drop         = pushReq && !push;
    levelNext    = levelReg;
    if (push && !pop)      levelNext = levelReg + LW'(1);
    else if (!push && pop) levelNext = levelReg - LW'(1);
    inumNext     = accept ? inumReg + 32'd1 : inumReg;
    if (accept && tr.ret_halt) stateNext = HALTED;
    overflowNext = overflowReg || drop;
    dropNext     = dropReg;
    if (drop && (dropReg != {CNT_W{1'b1}})) dropNext = dropReg + CNT_W'(1);
    doneNext     = (stateNext == HALTED) && (levelNext == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= RUN;
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      levelReg    <= '0;
      inumReg     <= '0;
      overflowReg <= 1'b0;
      dropReg     <= '0;
      doneReg     <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      levelReg    <= levelNext;
      inumReg     <= inumNext;
      overflowReg <= overflowNext;
      dropReg     <= dropNext;
      doneReg     <= doneNext;
      if (push) wrPtrReg <= wrPtrReg + AW'(1);
      if (pop)  rdPtrReg <= rdPtrReg + AW'(1);
    end
  end

  // Storage is not reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtrReg] <= recNext;
  end

  always_comb begin
    headRec = '0;
    if (levelReg != '0) headRec = mem[rdPtrReg];
  end

  assign tr.out_valid = (levelReg != '0);
  assign tr.out_inum  = headRec.inum;
  assign tr.out_kind  = headRec.kind;
  assign tr.out_pc    = headRec.pc;
  assign tr.out_reg   = headRec.rd;
  assign tr.out_value = headRec.value;
  assign tr.out_addr  = headRec.addr;
  assign tr.out_data  = headRec.data;

  assign halted     = (stateReg == HALTED);
  assign done       = doneReg;
  assign overflow   = overflowReg;
  assign drop_count = dropReg;
  assign level      = levelReg;
endmodule
